key_search: RTL and testbench

- Key-sweep controller that sits directly upstream of `arc4` in the cracking datapath.
- Drives `arc4`'s `en`/`key` handshake one candidate key at a time.
- Snoops the plaintext-memory write port (`pt_addr`/`pt_wrdata`/`pt_wren`) to judge each decryption.
- Stops on the first key whose plaintext is entirely printable ASCII, or when the key range is exhausted.

---
 rtl/key_search_pkg.sv | 19 +
 rtl/key_search_pt_printable_chk.sv | 31 +++
 rtl/key_search.sv | 117 +++++++++++
 tb/tb_key_search.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_search_pkg.sv
// Shared types and constants for the key_search slice.
// Optional KEY_SEARCH_PERF_EN adds a keys_tried counter in key_search.
package key_search_pkg;

    typedef logic [23:0] key_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        RUN,
        EVAL,
        DONE
    } state_t;

    localparam logic [7:0] CHAR_LO = 8'h20;
    localparam logic [7:0] CHAR_HI = 8'h7E;

endpackage

// File: rtl/key_search_pt_printable_chk.sv
// Sticky flag raised by any non-printable plaintext byte.
// The address-0 length byte is never judged.
module pt_printable_chk
    import key_search_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       chk_en,
    input  logic [7:0] pt_addr,
    input  logic [7:0] pt_wrdata,
    input  logic       pt_wren,
    output logic       bad
);

    logic hit;

    assign hit = chk_en && pt_wren && (pt_addr != 8'h00)
              && ((pt_wrdata < CHAR_LO) || (pt_wrdata > CHAR_HI));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad <= 1'b0;
        end else if (clr) begin
            bad <= 1'b0;
        end else if (hit) begin
            bad <= 1'b1;
        end
    end

endmodule

// File: rtl/key_search.sv
// Sweeps arc4 keys until the snooped plaintext is printable ASCII.
// Define KEY_SEARCH_PERF_EN to add the keys_tried output.
module key_search
    import key_search_pkg::*;
#(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    output logic        key_valid,
    output logic [23:0] key_found,
    output logic        arc4_en,
    output logic [23:0] arc4_key,
    input  logic        arc4_rdy,
    input  logic [7:0]  pt_addr,
    input  logic [7:0]  pt_wrdata,
    input  logic        pt_wren
`ifdef KEY_SEARCH_PERF_EN
    ,
    output logic [23:0] keys_tried
`endif
);

    state_t      state;
    key_t        cur_key;
    logic        bad;
    logic        go;
    logic        clr;
    logic [24:0] nxt_key;

    // 25-bit sum so a step past 24'hFFFFFF ends the sweep instead of wrapping
    assign nxt_key = {1'b0, cur_key} + {1'b0, KEY_STEP};
    assign go      = rdy && en;
    assign clr     = go || (state == EVAL);

    pt_printable_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .chk_en    (state == RUN),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren),
        .bad       (bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key_valid <= 1'b0;
            key_found <= '0;
            arc4_en   <= 1'b0;
            arc4_key  <= KEY_START;
            cur_key   <= KEY_START;
        end else begin
            arc4_en <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (en) begin
                        cur_key   <= KEY_START;
                        key_valid <= 1'b0;
                        rdy       <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (arc4_rdy) begin
                        arc4_en  <= 1'b1;
                        arc4_key <= cur_key;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!arc4_rdy) state <= RUN;
                end
                RUN: begin
                    if (arc4_rdy) state <= EVAL;
                end
                EVAL: begin
                    if (!bad) begin
                        key_found <= cur_key;
                        key_valid <= 1'b1;
                        rdy       <= 1'b1;
                        state     <= DONE;
                    end else if (nxt_key > {1'b0, KEY_MAX}) begin
                        key_found <= '0;
                        key_valid <= 1'b0;
                        rdy       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cur_key <= nxt_key[23:0];
                        state   <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_SEARCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_tried <= '0;
        end else if (go) begin
            keys_tried <= '0;
        end else if (state == EVAL && keys_tried != 24'hFFFFFF) begin
            keys_tried <= keys_tried + 24'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: three parameterisations driven by arc4 stubs.
// Honours KEY_SEARCH_PERF_EN when the RTL is built with it.
module tb_key_search;
    import key_search_pkg::*;

    localparam longint KS[3] = '{0, 'hFFFFFE, 1};
    localparam longint KT[3] = '{1, 1, 2};
    localparam longint KM[3] = '{'hFFFFFF, 'hFFFFFF, 9};
    localparam logic [24:0] NONE = 25'h1000000;

    logic clk = 0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_v[3];
    logic        rdy_v[3];
    logic        kv[3];
    logic [23:0] kf[3];
    logic        a_en[3];
    logic [23:0] a_key[3];
    logic        s_rdy[3];
    logic [7:0]  s_addr[3];
    logic [7:0]  s_data[3];
    logic        s_wren[3];
    int          s_cnt[3];
    bit          s_busy[3];
    key_t        s_key[3];
`ifdef KEY_SEARCH_PERF_EN
    logic [23:0] kt[3];
`endif

    key_t        seen[3][$];
    key_t        exp_q[$];
    int          cfg_len[3];
    logic [24:0] cfg_good[3];
    logic [7:0]  cfg_bad[3];
    bit          cfg_late[3];
    bit          cfg_rnd[3];
    int          n_checks = 0;
    int          n_fail = 0;

    key_search #(.KEY_START(24'h000000), .KEY_STEP(24'h000001),
                 .KEY_MAX(24'hFFFFFF)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]),
        .key_valid(kv[0]), .key_found(kf[0]), .arc4_en(a_en[0]),
        .arc4_key(a_key[0]), .arc4_rdy(s_rdy[0]), .pt_addr(s_addr[0]),
        .pt_wrdata(s_data[0]), .pt_wren(s_wren[0])
`ifdef KEY_SEARCH_PERF_EN
        , .keys_tried(kt[0])
`endif
    );

    key_search #(.KEY_START(24'hFFFFFE), .KEY_STEP(24'h000001),
                 .KEY_MAX(24'hFFFFFF)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]),
        .key_valid(kv[1]), .key_found(kf[1]), .arc4_en(a_en[1]),
        .arc4_key(a_key[1]), .arc4_rdy(s_rdy[1]), .pt_addr(s_addr[1]),
        .pt_wrdata(s_data[1]), .pt_wren(s_wren[1])
`ifdef KEY_SEARCH_PERF_EN
        , .keys_tried(kt[1])
`endif
    );

    key_search #(.KEY_START(24'h000001), .KEY_STEP(24'h000002),
                 .KEY_MAX(24'h000009)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rdy(rdy_v[2]),
        .key_valid(kv[2]), .key_found(kf[2]), .arc4_en(a_en[2]),
        .arc4_key(a_key[2]), .arc4_rdy(s_rdy[2]), .pt_addr(s_addr[2]),
        .pt_wrdata(s_data[2]), .pt_wren(s_wren[2])
`ifdef KEY_SEARCH_PERF_EN
        , .keys_tried(kt[2])
`endif
    );

    // One bad byte per wrong key; the good key (or len 0) is all printable.
    function automatic logic [7:0] msg_byte(int g, key_t k, int idx);
        int bp;
        bp = cfg_late[g] ? cfg_len[g] : 1 + int'(k % key_t'(cfg_len[g]));
        if ({1'b0, k} != cfg_good[g] && idx == bp) return cfg_bad[g];
        if (cfg_rnd[g]) return 8'(32 + ((int'(k) * 7 + idx * 13) % 95));
        return (idx % 2 == 1) ? 8'h20 : 8'h7E;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 3; g++) begin
                s_rdy[g] <= 1'b1;
                s_wren[g] <= 1'b0;
                s_addr[g] <= '0;
                s_data[g] <= '0;
                s_cnt[g] <= 0;
                s_busy[g] <= 1'b0;
                s_key[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                s_wren[g] <= 1'b0;
                if (!s_busy[g]) begin
                    if (a_en[g]) begin
                        s_busy[g] <= 1'b1;
                        s_rdy[g] <= 1'b0;
                        s_cnt[g] <= 0;
                        s_key[g] <= a_key[g];
                        seen[g].push_back(a_key[g]);
                    end
                end else begin
                    if (s_cnt[g] <= cfg_len[g]) begin
                        s_wren[g] <= 1'b1;
                        s_addr[g] <= 8'(s_cnt[g]);
                        s_data[g] <= (s_cnt[g] == 0) ? 8'(cfg_len[g])
                                   : msg_byte(g, s_key[g], s_cnt[g]);
                    end
                    if ((cfg_late[g] && s_cnt[g] == cfg_len[g])
                        || s_cnt[g] == cfg_len[g] + 2) begin
                        s_rdy[g] <= 1'b1;
                        s_busy[g] <= 1'b0;
                    end
                    s_cnt[g] <= s_cnt[g] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the key range by plain arithmetic.
    task automatic model(input int g, output bit valid, output key_t found);
        longint k;
        k = KS[g];
        exp_q.delete();
        valid = 0;
        found = '0;
        while (k <= KM[g]) begin
            exp_q.push_back(key_t'(k));
            if (cfg_len[g] == 0 || k == longint'(cfg_good[g])) begin
                valid = 1;
                found = key_t'(k);
                return;
            end
            k += KT[g];
        end
    endtask

    task automatic set_cfg(input int g, input logic [24:0] good, input int len,
                           input logic [7:0] bad, input bit late, input bit rnd);
        cfg_good[g] = good;
        cfg_len[g] = len;
        cfg_bad[g] = bad;
        cfg_late[g] = late;
        cfg_rnd[g] = rnd;
    endtask

    task automatic wait_rdy(input int g, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rdy_v[g]) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_done"}, ok, 1);
    endtask

    task automatic pulse_en(input int g);
        @(negedge clk);
        en_v[g] = 1;
        @(negedge clk);
        en_v[g] = 0;
    endtask

    task automatic run_case(input int g, input string name, input bit ev,
                            input key_t ef, input int en_keys);
        int base;
        int n;
        base = seen[g].size();
        pulse_en(g);
        wait_rdy(g, name);
        n = seen[g].size() - base;
        chk({name, "_rdy"}, rdy_v[g], 1);
        chk({name, "_valid"}, kv[g], ev);
        chk({name, "_found"}, kf[g], ef);
        chk({name, "_nkeys"}, n, en_keys);
        chk({name, "_nmodel"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({name, "_key"}, seen[g][base + i], exp_q[i]);
`ifdef KEY_SEARCH_PERF_EN
        chk({name, "_tried"}, kt[g], en_keys);
`endif
    endtask

    typedef struct {
        logic [24:0] good;
        int          len;
        logic [7:0]  bad;
        bit          late;
        bit          ev;
        key_t        ef;
        int          n;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit   mv;
        key_t mf;
        int   base;
        bit   ok;

        vt[0] = '{25'd3, 4, 8'h1F, 1'b0, 1'b1, 24'd3, 4};
        vt[1] = '{25'd2, 5, 8'h7F, 1'b0, 1'b1, 24'd2, 3};
        vt[2] = '{25'd5, 1, 8'h80, 1'b1, 1'b1, 24'd5, 6};
        vt[3] = '{25'd4, 0, 8'h1F, 1'b0, 1'b1, 24'd0, 1};
        vt[4] = '{25'd1, 2, 8'h00, 1'b1, 1'b1, 24'd1, 2};
        vt[5] = '{25'd0, 3, 8'h7F, 1'b0, 1'b1, 24'd0, 1};

        rst_n = 0;
        for (int g = 0; g < 3; g++) begin
            en_v[g] = 0;
            set_cfg(g, NONE, 3, 8'h1F, 0, 0);
        end
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy_v[0], 1);
        chk("rst_valid", kv[0], 0);
        chk("rst_found", kf[0], 0);
        chk("rst_arc4_en", a_en[0], 0);
        chk("rst_key0", a_key[0], 24'h000000);
        chk("rst_key1", a_key[1], 24'hFFFFFE);
`ifdef KEY_SEARCH_PERF_EN
        chk("rst_tried", kt[0], 0);
`endif
        rst_n = 1;

        for (int i = 0; i < 6; i++) begin
            set_cfg(0, vt[i].good, vt[i].len, vt[i].bad, vt[i].late, 0);
            model(0, mv, mf);
            run_case(0, $sformatf("vec%0d", i), vt[i].ev, vt[i].ef, vt[i].n);
        end

        set_cfg(1, NONE, 3, 8'h1F, 0, 0);
        model(1, mv, mf);
        run_case(1, "top_end", 0, 24'h0, 2);
        chk("top_end_key", a_key[1], 24'hFFFFFF);

        set_cfg(2, 25'd5, 3, 8'h7F, 0, 0);
        model(2, mv, mf);
        run_case(2, "step2_hit", 1, 24'd5, 3);
        set_cfg(2, 25'd4, 3, 8'h7F, 0, 0);
        model(2, mv, mf);
        run_case(2, "step2_miss", 0, 24'd0, 5);

        // en while busy must not restart the sweep
        set_cfg(0, 25'd3, 4, 8'h1F, 0, 0);
        model(0, mv, mf);
        base = seen[0].size();
        pulse_en(0);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (seen[0].size() - base == 2);
        end
        chk("busy_reach", ok, 1);
        pulse_en(0);
        wait_rdy(0, "busy_en");
        chk("busy_nkeys", seen[0].size() - base, 4);
        chk("busy_found", kf[0], 24'd3);

        // reset in the middle of key 2
        set_cfg(0, 25'd5, 4, 8'h1F, 0, 0);
        base = seen[0].size();
        pulse_en(0);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (seen[0].size() - base == 3) && (s_cnt[0] >= 3);
        end
        chk("mid_reach", ok, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rdy", rdy_v[0], 1);
        chk("mid_arc4_en", a_en[0], 0);
        chk("mid_valid", kv[0], 0);
        @(negedge clk);
        rst_n = 1;
        set_cfg(0, 25'd1, 3, 8'h1F, 0, 0);
        model(0, mv, mf);
        run_case(0, "restart", 1, 24'd1, 2);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] bb;
            bb = $urandom_range(0, 1) ? 8'($urandom_range(0, 31))
                                      : 8'($urandom_range(127, 255));
            set_cfg(0, 25'($urandom_range(0, 6)), $urandom_range(0, 5), bb,
                    1'($urandom_range(0, 1)), 1);
            model(0, mv, mf);
            run_case(0, $sformatf("rnd%0d", r), mv, mf, exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
